// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, line/frame counters, sync and visible-window decode,
// plus the frame and game-logic update strobes derived from the end of each frame.
module vga_timing_gen #(
    parameter int PIX_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int MOVE_FRAMES = 1
) (
    input  logic       clk,
    input  logic       Reset,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick,
    output logic       move_tick,
    output logic [7:0] frame_count
);

    localparam int               DIV_W    = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [7:0]       MV_LAST  = 8'(MOVE_FRAMES - 1);

    localparam logic [9:0] H_SYNC_END     = 10'd96;
    localparam logic [9:0] H_BRIGHT_FIRST = 10'd144;
    localparam logic [9:0] H_BRIGHT_LAST  = 10'd783;
    localparam logic [9:0] V_SYNC_END     = 10'd2;
    localparam logic [9:0] V_BRIGHT_FIRST = 10'd35;
    localparam logic [9:0] V_BRIGHT_LAST  = 10'd514;

    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       mv_cnt;
    logic             lineEnd;
    logic             frameEnd;

    assign pix_en   = (div_cnt == DIV_LAST);
    assign lineEnd  = pix_en && (hCount == H_LAST);
    assign frameEnd = lineEnd && (vCount == V_LAST);

    // Sync and visible-window decode straight from the counters, so they never lag the position.
    always_comb begin
        hSync  = (hCount >= H_SYNC_END);
        vSync  = (vCount >= V_SYNC_END);
        bright = (hCount >= H_BRIGHT_FIRST) && (hCount <= H_BRIGHT_LAST) &&
                 (vCount >= V_BRIGHT_FIRST) && (vCount <= V_BRIGHT_LAST);
    end

    // Pixel divider and raster position; the position only moves on a pixel slot.
    always_ff @(posedge clk) begin
        if (Reset) begin
            div_cnt <= '0;
            hCount  <= '0;
            vCount  <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            if (pix_en) begin
                hCount <= lineEnd ? '0 : hCount + 10'd1;
            end
            if (lineEnd) begin
                vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
            end
        end
    end

    // Frame-level strobes are registered off the frame-end slot, landing on position 0,0.
    always_ff @(posedge clk) begin
        if (Reset) begin
            frame_tick  <= 1'b0;
            move_tick   <= 1'b0;
            mv_cnt      <= '0;
            frame_count <= '0;
        end else begin
            frame_tick <= frameEnd;
            move_tick  <= 1'b0;
            if (frameEnd) begin
                frame_count <= frame_count + 8'd1;
                if (mv_cnt == MV_LAST) begin
                    mv_cnt    <= '0;
                    move_tick <= 1'b1;
                end else begin
                    mv_cnt <= mv_cnt + 8'd1;
                end
            end
        end
    end

endmodule
